// File: rtl/sram_read_sequencer.sv
// sram_read_sequencer: read-phase sequencer (precharge -> wordline/develop -> sense -> output handshake)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   rd_req, rd_addr, rd_ready request side; accepted in IDLE, address latched on accept
//   precharge, wl_sel, sae    array controls (precharge enable, one-hot wordline, sense-amp strobe)
//   preout                    sense-amp outputs, captured at the end of SENSE
//   rd_data, rd_valid, rd_err output word with valid/ready handshake against rd_out_ready
// Optional: SRAM_SA_DOUBLE_SAMPLE_EN gives a two-cycle SENSE; rd_err also flags disagreeing samples.
module sram_read_sequencer #(
  parameter int COLS    = 16,
  parameter int ROWS    = 16,
  parameter int ADDR_W  = 4,
  parameter int PRE_CYC = 2,
  parameter int DEV_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              precharge,
  output logic [ROWS-1:0]   wl_sel,
  output logic              sae,
  input  logic [COLS-1:0]   preout,
  output logic [COLS-1:0]   rd_data,
  output logic              rd_valid,
  input  logic              rd_out_ready,
  output logic              rd_err
);
  localparam int CW = $clog2((PRE_CYC > DEV_CYC ? PRE_CYC : DEV_CYC) + 1);
`ifdef SRAM_SA_DOUBLE_SAMPLE_EN
  localparam int SNS_CYC = 2;
`else
  localparam int SNS_CYC = 1;
`endif
  typedef enum logic [2:0] {IDLE, PRECH, DEVELOP, SENSE, OUT} state_t;
  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_oor;
  logic [ROWS-1:0]   w_onehot;
  logic              w_cap;
`ifdef SRAM_SA_DOUBLE_SAMPLE_EN
  logic [COLS-1:0]   r_s1;
`endif
  // Phase counter counts down from (duration-1) and saturates at zero outside timed phases.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
    case (r_state)
      IDLE:    if (rd_req) begin
                 w_state_nxt = PRECH;
                 w_cnt_nxt   = CW'(PRE_CYC - 1);
               end
      PRECH:   if (r_cnt == '0) begin
                 w_state_nxt = DEVELOP;
                 w_cnt_nxt   = CW'(DEV_CYC - 1);
               end
      DEVELOP: if (r_cnt == '0) begin
                 w_state_nxt = SENSE;
                 w_cnt_nxt   = CW'(SNS_CYC - 1);
               end
      SENSE:   if (r_cnt == '0) w_state_nxt = OUT;
      OUT:     if (rd_out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // Out-of-range rows never drive a wordline; sae is suppressed with it so sae never fires on an idle array.
  assign w_onehot = r_oor ? '0 : ROWS'(1) << r_addr;
  assign w_cap    = (r_state == SENSE) && (r_cnt == '0);
  // Outputs are decoded from the next state so every control pin comes straight off a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_oor     <= 1'b0;
      rd_ready  <= 1'b1;
      precharge <= 1'b0;
      wl_sel    <= '0;
      sae       <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
`ifdef SRAM_SA_DOUBLE_SAMPLE_EN
      r_s1      <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (r_state == IDLE && rd_req) begin
        r_addr <= rd_addr;
        r_oor  <= int'(rd_addr) >= ROWS;
      end
      rd_ready  <= w_state_nxt == IDLE;
      precharge <= w_state_nxt == PRECH;
      wl_sel    <= (w_state_nxt == DEVELOP || w_state_nxt == SENSE) ? w_onehot : '0;
      sae       <= (w_state_nxt == SENSE) && !r_oor;
      rd_valid  <= w_state_nxt == OUT;
`ifdef SRAM_SA_DOUBLE_SAMPLE_EN
      if (r_state == SENSE && r_cnt != '0) r_s1 <= preout;
      if (w_cap) begin
        rd_data <= preout;
        rd_err  <= r_oor || (r_s1 != preout);
      end
`else
      if (w_cap) begin
        rd_data <= preout;
        rd_err  <= r_oor;
      end
`endif
    end
  end
endmodule

// File: doc/sram_read_sequencer.md
Name: sram_read_sequencer

Overview:
- Read-timing controller for the mixed-signal SRAM column path; sits directly upstream of the differential sense-amp array.
- Accepts one read request at a time and sequences the phases: bitline precharge, then wordline assert with bitline development, then sense-amp enable.
- Captures the sense-amp preout vector into a holding register and presents it on a valid/ready output handshake.

Parameters:
- COLS, 16, number of columns; width of preout and rd_data.
- ROWS, 16, number of wordlines; width of wl_sel.
- ADDR_W, 4, row address width; must satisfy 2**ADDR_W >= ROWS.
- PRE_CYC, 2, precharge duration in cycles; must be >= 1.
- DEV_CYC, 2, bitline development duration in cycles with wordline high; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_req  input  1  read request; qualified by rd_ready.
- rd_addr  input  ADDR_W  row address; sampled on accept.
- rd_ready  output  1  sequencer idle and able to accept a request.
- precharge  output  1  bitline precharge enable to the array.
- wl_sel  output  ROWS  one-hot wordline enable.
- sae  output  1  sense-amp enable strobe.
- preout  input  COLS  differential sense-amp outputs.
- rd_data  output  COLS  captured read word.
- rd_valid  output  1  rd_data valid.
- rd_out_ready  input  1  consumer ready for rd_data.
- rd_err  output  1  error flag; meaningful only while rd_valid is high.

Behaviour:
- Reset (async, active-high, any state): FSM goes to IDLE, counter cleared. Outputs: rd_ready=1, precharge=0, wl_sel=0, sae=0, rd_data=0, rd_valid=0, rd_err=0. A sequence in flight is abandoned; no partial data is delivered.
- FSM states:
  - IDLE -> PRECH, PRECH -> DEVELOP, DEVELOP -> SENSE, SENSE -> OUT, OUT -> IDLE.
  - All outputs are registered.
- IDLE:
  - rd_ready=1.
  - Accept occurs at a rising edge where rd_req=1 in IDLE; rd_addr is latched there.
  - rd_req while not in IDLE is ignored and not queued.
- PRECH: precharge=1 for exactly PRE_CYC cycles; wl_sel=0; sae=0.
- DEVELOP: precharge=0; wl_sel = one-hot of the latched address for DEV_CYC cycles.
- SENSE (one cycle):
  - wl_sel held and sae=1.
  - preout is captured into rd_data at the edge that ends SENSE.
  - wl_sel and sae drop to 0 at that same edge.
- OUT:
  - rd_valid=1; rd_data and rd_err are held stable while rd_valid=1 and rd_out_ready=0.
  - At the edge where rd_valid and rd_out_ready are both 1: rd_valid goes to 0 and the FSM returns to IDLE.
  - rd_ready is 1 from the next cycle; there is no back-to-back bypass.
- Latency (accept edge = cycle 0):
  - precharge high during cycles 1..PRE_CYC.
  - rd_valid first high in cycle PRE_CYC+DEV_CYC+2; cycle 6 with default parameters.
  - Minimum request-to-request period is PRE_CYC+DEV_CYC+3 cycles.
- Mutual exclusion: precharge, any wl_sel bit, and sae are never high in a way that shorts the bitlines. precharge is never high together with any wl_sel bit; sae is high only while wl_sel is nonzero.
- Out-of-range address (rd_addr >= ROWS):
  - The request is accepted and the full sequence is run, but wl_sel stays all-zero.
  - rd_data captures whatever preout shows; rd_err=1 while rd_valid is high.
- Phase counter: width clog2(max(PRE_CYC,DEV_CYC)+1); reloaded on each phase entry; it never wraps.

Optional Feature:
- Macro: SRAM_SA_DOUBLE_SAMPLE_EN.
- Defined:
  - SENSE lasts 2 cycles with sae=1 throughout; preout is sampled at both edges.
  - rd_data takes the second sample.
  - rd_err = (sample1 != sample2) OR out-of-range.
  - Latency becomes PRE_CYC+DEV_CYC+3.
- Undefined: single-cycle SENSE; rd_err reports out-of-range only.

Test Plan:
- Reset then idle: rd_ready=1, all other outputs 0; hold rd_req=0 for 20 cycles -> no output toggles.
- Defaults, accept rd_addr=5, preout=16'hA5C3 during SENSE, rd_out_ready=1 -> precharge high cycles 1-2; wl_sel=16'h0020 cycles 3-5; sae high cycle 5; rd_valid=1 cycle 6 with rd_data=16'hA5C3, rd_err=0; rd_ready=1 cycle 7.
- Backpressure: rd_out_ready=0 for 10 cycles after rd_valid, preout changed to 16'h0000 meanwhile -> rd_data stays 16'hA5C3 and rd_valid stays 1; a single-cycle rd_out_ready pulse ends OUT.
- ROWS=12, rd_addr=14 -> wl_sel=0 throughout; rd_valid asserted with rd_err=1.
- Assert rst in DEVELOP with rd_addr=3 -> wl_sel and all outputs 0 immediately (asynchronously); after release, a fresh read of rd_addr=7 completes with correct timing.
- With SRAM_SA_DOUBLE_SAMPLE_EN: preout 16'h00FF at the first SENSE edge and 16'h00FE at the second -> rd_data=16'h00FE, rd_err=1, rd_valid in cycle 7.
